rng_pool_reader: RTL and testbench
==================================

# rng_pool_reader

Consumer end of the ring-oscillator TRNG buffer handshake. Waits for the TRNG's `rng_ready`, captures its full `BUFFER_SIZE`-bit buffer into a local pool and immediately pulses `req` so the TRNG refills in the background. It then serves the pool to the loop shuffler as `WORD_W`-bit words over a valid/ready stream. It sits between the TRNG macro and the shuffler's permutation logic.

## Interface
- `BUFFER_SIZE`, 256, TRNG buffer width. Must be a multiple of `WORD_W` and at least `WORD_W`.
- `WORD_W`, 32, width of each served random word.
- `clk`  in  1  sole clock, shared with the TRNG.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `trng_ready_i`  in  1  TRNG buffer full (TRNG `rng_ready_o`).
- `trng_buffer_i`  in  `BUFFER_SIZE`  TRNG buffer contents (TRNG `buffer_out`).
- `trng_req_o`  out  1  one-cycle pulse; the TRNG clears its buffer and `rng_ready` on the next edge.
- `rnd_valid_o`  out  1  a random word is available.
- `rnd_ready_i`  in  1  consumer accepts the word.
- `rnd_data_o`  out  `WORD_W`  current random word.
- `health_err_o`  out  1  sticky stuck-source flag (see Configuration).

## Operation
- Local `NWORDS = BUFFER_SIZE/WORD_W`. Word index `idx` is `$clog2(NWORDS)` bits wide, minimum 1.
- FSM states: `FILL`, `SERVE`.
- **FILL**
  - `rnd_valid_o`=0.
  - On an edge with `trng_ready_i`=1: `pool<=trng_buffer_i`, `idx<=0`, `trng_req_o<=1`, go to `SERVE`.
- **SERVE**
  - `rnd_valid_o`=1.
  - `rnd_data_o = pool[WORD_W*idx +: WORD_W]`, so word 0 is the LSBs.
  - `trng_req_o` returns to 0 after its single cycle.
  - Transfer occurs when `rnd_valid_o && rnd_ready_i`.
    - `idx<NWORDS-1`: `idx<=idx+1`.
    - `idx==NWORDS-1`: go to `FILL`.
  - `trng_ready_i` is ignored in `SERVE`.
- A word is never served twice. Each pool bit is served exactly once.
- `rnd_data_o` holds stable while `rnd_valid_o`=1 and `rnd_ready_i`=0.
- `rnd_ready_i` asserted in `FILL` has no effect.
- Reset (async assert, mid-operation included):
  - state=`FILL`, `pool`=0, `idx`=0.
  - `trng_req_o`=0, `rnd_valid_o`=0, `rnd_data_o`=0, `health_err_o`=0.
  - Any partially served pool is discarded.

## Timing
- Capture to first valid word: 1 cycle. The capture edge is the same edge at which `trng_req_o` and `rnd_valid_o` rise.
- Throughput in `SERVE`: 1 word/cycle.
- After the last-word transfer, `FILL` is entered on the next edge.
  - If the TRNG is already ready, the new capture happens at the following edge.
  - The bubble is 1 cycle of `rnd_valid_o`=0.
- `trng_req_o` is registered and high for exactly one cycle per capture. The TRNG drops `rng_ready` on the edge ending that cycle.
  - This holds even when `NWORDS`=1: `FILL` is re-entered no earlier than the cycle in which `trng_ready_i` is already 0, so the same buffer is never captured twice.

## Configuration
- `RNG_POOL_HEALTH_EN`, defined:
  - In `FILL` with `trng_ready_i`=1, a buffer that is all-zeros or all-ones is rejected.
    - `pool` and `idx` are not updated.
    - `trng_req_o` still pulses, to force a refill.
    - State stays `FILL`.
    - A 3-bit consecutive-reject counter increments, saturating at 7.
  - An accepted buffer clears the counter.
  - When the counter reaches 4, `health_err_o`<=1. It stays set until reset.
  - Serving continues normally after the flag is set.
- `RNG_POOL_HEALTH_EN`, not defined:
  - No check; every ready buffer is accepted.
  - `health_err_o` is tied 0 and the counter is not built.

## Structure
- Shared package `rng_pkg`:
  - FSM state typedef `rng_pool_state_t` {`FILL`, `SERVE`}.
  - Constant `RNG_HEALTH_REJECT_LIMIT`=4.
- Parameter-derived localparams (`NWORDS`, index width) stay local to the module.
- One sub-module, `rng_health_mon`:
  - Inputs: candidate buffer, capture strobe.
  - Outputs: `reject`, sticky `health_err`.
  - Instantiated only under `RNG_POOL_HEALTH_EN`.

## Test plan
- Basic: `BUFFER_SIZE`=256, `WORD_W`=32, buffer=0x…_00000007_…_00000000 (word k = k), ready=1, `rnd_ready_i`=1 → valid the cycle after capture; `rnd_data_o`=0,1,…,7 on consecutive cycles; `trng_req_o` pulses exactly once, on the first valid cycle.
- Backpressure: `rnd_ready_i` toggling 0/1 → each word held stable while stalled; exactly 8 transfers per pool; no duplicates.
- `NWORDS`=1 (`BUFFER_SIZE`=`WORD_W`=32), TRNG model clears ready one edge after req → each buffer captured once; exactly one req per capture.
- Reset: assert `reset_n`=0 after word 3 → all outputs 0 immediately; after release, waits for ready; next pool restarts at word 0.
- Health, macro on: four consecutive all-ones buffers → four req pulses, no valid, `health_err_o`=1 after the 4th; a following random buffer is served normally and `health_err_o` stays 1.
- Health, macro off: all-zeros buffer → served as eight zero words; `health_err_o`=0.

Source files
------------

// File: rtl/rng_pkg.sv
// rng_pkg: shared types and constants for the TRNG pool reader.
//   rng_pool_state_t        - pool reader FSM states (FILL, SERVE)
//   RNG_HEALTH_REJECT_LIMIT - consecutive stuck buffers that raise the health flag
package rng_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        SERVE = 1'b1
    } rng_pool_state_t;

    localparam int RNG_HEALTH_REJECT_LIMIT = 4;

endpackage

// File: rtl/rng_health_mon.sv
// rng_health_mon: stuck-source detector for TRNG buffers.
// Flags an all-zeros or all-ones buffer as rejected and counts consecutive
// rejections (3-bit, saturating at 7). Reaching RNG_HEALTH_REJECT_LIMIT sets a
// sticky error that only reset clears.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   buffer        - candidate TRNG buffer
//   strobe        - a buffer is being offered for capture this cycle
//   reject        - combinational: candidate buffer is stuck
//   health_err    - sticky stuck-source flag
module rng_health_mon
    import rng_pkg::*;
#(
    parameter int BUFFER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [BUFFER_SIZE-1:0] buffer,
    input  logic                   strobe,
    output logic                   reject,
    output logic                   health_err
);

    localparam logic [2:0] ERR_AT = 3'(RNG_HEALTH_REJECT_LIMIT - 1);

    logic [2:0] reject_cnt;

    assign reject = (buffer == '0) || (&buffer);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reject_cnt <= '0;
            health_err <= 1'b0;
        end else if (strobe) begin
            if (reject) begin
                if (reject_cnt != 3'd7) begin
                    reject_cnt <= reject_cnt + 3'd1;
                end
                // This rejection brings the count to the limit.
                if (reject_cnt == ERR_AT) begin
                    health_err <= 1'b1;
                end
            end else begin
                reject_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rng_pool_reader.sv
// rng_pool_reader: consumer side of the TRNG buffer handshake.
// Captures the full TRNG buffer into a local pool when trng_ready_i is high,
// pulses trng_req_o for one cycle so the TRNG refills in the background, then
// serves the pool as WORD_W-bit words (word 0 = LSBs) over valid/ready.
// Optional feature: define RNG_POOL_HEALTH_EN to reject all-zeros/all-ones
// buffers and raise a sticky health_err_o after repeated rejections.
// Ports:
//   clk, reset_n   - clock (shared with TRNG), asynchronous active-low reset
//   trng_ready_i   - TRNG buffer full
//   trng_buffer_i  - TRNG buffer contents
//   trng_req_o     - one-cycle refill request to the TRNG
//   rnd_valid_o    - random word available
//   rnd_ready_i    - consumer accepts the word
//   rnd_data_o     - current random word
//   health_err_o   - sticky stuck-source flag (0 when the check is not built)
module rng_pool_reader
    import rng_pkg::*;
#(
    parameter int BUFFER_SIZE = 256,
    parameter int WORD_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trng_ready_i,
    input  logic [BUFFER_SIZE-1:0] trng_buffer_i,
    output logic                   trng_req_o,
    output logic                   rnd_valid_o,
    input  logic                   rnd_ready_i,
    output logic [WORD_W-1:0]      rnd_data_o,
    output logic                   health_err_o
);

    localparam int NWORDS = BUFFER_SIZE / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    rng_pool_state_t        state_q, state_d;
    logic [BUFFER_SIZE-1:0] pool_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   req_q;
    logic                   offer;
    logic                   accept;
    logic                   transfer;
    logic                   reject;

    // NOTE: every signal driven here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        offer    = 1'b0;
        accept   = 1'b0;
        transfer = 1'b0;
        unique case (state_q)
            FILL: begin
                // While the refill request is still out the TRNG has not yet
                // dropped ready, so the buffer on its port is the one just seen.
                offer  = trng_ready_i && !req_q;
                accept = offer && !reject;
                if (accept) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                transfer = rnd_ready_i;
                if (transfer && (idx_q == LAST_IDX)) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the pool is reset (not left uninitialised like a RAM) because its
    // contents drive rnd_data_o and must read as zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pool_q <= '0;
            idx_q  <= '0;
            req_q  <= 1'b0;
        end else begin
            // Any offered buffer, accepted or rejected, is consumed by a refill.
            req_q <= offer;
            if (accept) begin
                pool_q <= trng_buffer_i;
                idx_q  <= '0;
            end else if (transfer && (idx_q != LAST_IDX)) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign trng_req_o  = req_q;
    assign rnd_valid_o = (state_q == SERVE);
    assign rnd_data_o  = rnd_valid_o ? pool_q[int'(idx_q) * WORD_W +: WORD_W] : '0;

`ifdef RNG_POOL_HEALTH_EN
    rng_health_mon #(
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_health (
        .clk        (clk),
        .reset_n    (reset_n),
        .buffer     (trng_buffer_i),
        .strobe     (offer),
        .reject     (reject),
        .health_err (health_err_o)
    );
`else
    assign reject       = 1'b0;
    assign health_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rng_pool_reader.sv
// tb_rng_pool_reader: directed self-checking bench for rng_pool_reader.
// DUT a: 256-bit buffer / 32-bit words. DUT b: 32-bit buffer / 32-bit words.
// Each TRNG model raises ready when the bench offers a buffer and drops it on
// the edge after it sees trng_req_o.
module tb_rng_pool_reader;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rnd_ready = 1'b0;

    logic [255:0] buf_a = '0;
    logic         req_a, valid_a, herr_a;
    logic [31:0]  data_a;
    int           offer_a = 0;
    int           taken_a = 0;
    logic         ready_a;

    logic [31:0]  buf_b = '0;
    logic         req_b, valid_b, herr_b;
    logic [31:0]  data_b;
    int           offer_b = 0;
    int           taken_b = 0;
    logic         ready_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign ready_a = (offer_a != taken_a);
    assign ready_b = (offer_b != taken_b);
    always @(posedge clk) if (req_a) taken_a <= taken_a + 1;
    always @(posedge clk) if (req_b) taken_b <= taken_b + 1;

    rng_pool_reader #(.BUFFER_SIZE(256), .WORD_W(32)) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .trng_ready_i  (ready_a),
        .trng_buffer_i (buf_a),
        .trng_req_o    (req_a),
        .rnd_valid_o   (valid_a),
        .rnd_ready_i   (rnd_ready),
        .rnd_data_o    (data_a),
        .health_err_o  (herr_a)
    );

    rng_pool_reader #(.BUFFER_SIZE(32), .WORD_W(32)) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .trng_ready_i  (ready_b),
        .trng_buffer_i (buf_b),
        .trng_req_o    (req_b),
        .rnd_valid_o   (valid_b),
        .rnd_ready_i   (rnd_ready),
        .rnd_data_o    (data_b),
        .health_err_o  (herr_b)
    );

    // Buffer whose word k holds base + k.
    function automatic logic [255:0] make_buf(input logic [31:0] base);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = base + 32'(k);
        return b;
    endfunction

    task automatic test_reset();
        #1;
        checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_a); else passes++;
        checks++; if (req_a !== 1'b0) $display("FAIL reset_req got=%b exp=0", req_a); else passes++;
        checks++; if (data_a !== 32'h0) $display("FAIL reset_data got=%h exp=0", data_a); else passes++;
        checks++; if (herr_a !== 1'b0) $display("FAIL reset_herr got=%b exp=0", herr_a); else passes++;
        checks++; if (valid_b !== 1'b0) $display("FAIL reset_valid_b got=%b exp=0", valid_b); else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (valid_a !== 1'b0) $display("FAIL idle_valid got=%b exp=0", valid_a); else passes++;
    endtask

    task automatic test_basic();
        rnd_ready = 1'b1;
        buf_a = make_buf(32'h0);
        offer_a++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (valid_a !== 1'b1) $display("FAIL basic_valid w%0d got=%b exp=1", k, valid_a); else passes++;
            checks++; if (data_a !== 32'(k)) $display("FAIL basic_data w%0d got=%h exp=%h", k, data_a, 32'(k)); else passes++;
            checks++; if (req_a !== (k == 0)) $display("FAIL basic_req w%0d got=%b exp=%b", k, req_a, (k == 0)); else passes++;
        end
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) $display("FAIL basic_end_valid got=%b exp=0", valid_a); else passes++;
        checks++; if (ready_a !== 1'b0) $display("FAIL basic_trng_ready got=%b exp=0", ready_a); else passes++;
    endtask

    // Stalls with a fixed pattern; the next buffer is offered while the first
    // is still being served, so refill after the last word costs one bubble.
    task automatic test_back_to_back();
        int exp_idx = 0;
        int xfers = 0;
        bit next_offered = 0;
        rnd_ready = 1'b0;
        buf_a = make_buf(32'h100);
        offer_a++;
        for (int cyc = 0; cyc < 60 && exp_idx < 8; cyc++) begin
            @(negedge clk);
            if (valid_a) begin
                checks++;
                if (data_a !== 32'h100 + 32'(exp_idx))
                    $display("FAIL bp_data cyc%0d got=%h exp=%h", cyc, data_a, 32'h100 + 32'(exp_idx));
                else passes++;
            end
            if (exp_idx >= 5 && !next_offered) begin
                buf_a = make_buf(32'h300);
                offer_a++;
                next_offered = 1;
            end
            rnd_ready = (cyc % 3) != 0;
            if (valid_a && rnd_ready) begin
                exp_idx++;
                xfers++;
            end
        end
        checks++; if (xfers !== 8) $display("FAIL bp_xfers got=%0d exp=8", xfers); else passes++;
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) $display("FAIL bp_bubble got=%b exp=0", valid_a); else passes++;
        @(negedge clk);
        checks++; if (valid_a !== 1'b1) $display("FAIL bp_refill_valid got=%b exp=1", valid_a); else passes++;
        checks++; if (data_a !== 32'h300) $display("FAIL bp_refill_data got=%h exp=300", data_a); else passes++;
        checks++; if (req_a !== 1'b1) $display("FAIL bp_refill_req got=%b exp=1", req_a); else passes++;
        rnd_ready = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (valid_a !== 1'b0) $display("FAIL bp_drain got=%b exp=0", valid_a); else passes++;
    endtask

    task automatic test_reset_mid();
        rnd_ready = 1'b1;
        buf_a = make_buf(32'h500);
        offer_a++;
        repeat (5) @(negedge clk);
        checks++; if (data_a !== 32'h504) $display("FAIL rst_pre_data got=%h exp=504", data_a); else passes++;
        reset_n = 1'b0;
        #1;
        checks++; if (valid_a !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", valid_a); else passes++;
        checks++; if (data_a !== 32'h0) $display("FAIL rst_mid_data got=%h exp=0", data_a); else passes++;
        checks++; if (req_a !== 1'b0) $display("FAIL rst_mid_req got=%b exp=0", req_a); else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (valid_a !== 1'b0) $display("FAIL rst_wait_valid got=%b exp=0", valid_a); else passes++;
        buf_a = make_buf(32'h600);
        offer_a++;
        @(negedge clk);
        checks++; if (data_a !== 32'h600) $display("FAIL rst_restart_data got=%h exp=600", data_a); else passes++;
        checks++; if (valid_a !== 1'b1) $display("FAIL rst_restart_valid got=%b exp=1", valid_a); else passes++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [31:0] vals [2];
        vals[0] = 32'hA5A5_0001;
        vals[1] = 32'h5A5A_0002;
        rnd_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            int reqs = 0;
            int served = 0;
            buf_b = vals[p];
            offer_b++;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (req_b) reqs++;
                if (valid_b) begin
                    served++;
                    checks++;
                    if (data_b !== vals[p]) $display("FAIL nw1_data p%0d got=%h exp=%h", p, data_b, vals[p]);
                    else passes++;
                end
            end
            checks++; if (reqs !== 1) $display("FAIL nw1_reqs p%0d got=%0d exp=1", p, reqs); else passes++;
            checks++; if (served !== 1) $display("FAIL nw1_served p%0d got=%0d exp=1", p, served); else passes++;
        end
    endtask

`ifdef RNG_POOL_HEALTH_EN
    task automatic test_health();
        int reqs = 0;
        int valids = 0;
        rnd_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            buf_a = '1;
            offer_a++;
            repeat (3) begin
                @(negedge clk);
                if (req_a) reqs++;
                if (valid_a) valids++;
            end
            if (r == 2) begin
                checks++; if (herr_a !== 1'b0) $display("FAIL health_early got=%b exp=0", herr_a); else passes++;
            end
        end
        checks++; if (reqs !== 4) $display("FAIL health_reqs got=%0d exp=4", reqs); else passes++;
        checks++; if (valids !== 0) $display("FAIL health_valids got=%0d exp=0", valids); else passes++;
        checks++; if (herr_a !== 1'b1) $display("FAIL health_err got=%b exp=1", herr_a); else passes++;
        buf_a = make_buf(32'h1234_0000);
        offer_a++;
        @(negedge clk);
        checks++; if (valid_a !== 1'b1) $display("FAIL health_serve_valid got=%b exp=1", valid_a); else passes++;
        checks++; if (data_a !== 32'h1234_0000) $display("FAIL health_serve_data got=%h exp=12340000", data_a); else passes++;
        repeat (8) @(negedge clk);
        checks++; if (herr_a !== 1'b1) $display("FAIL health_sticky got=%b exp=1", herr_a); else passes++;
    endtask
`else
    task automatic test_health();
        int served = 0;
        rnd_ready = 1'b1;
        buf_a = '0;
        offer_a++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_a) begin
                served++;
                checks++;
                if (data_a !== 32'h0) $display("FAIL zero_data c%0d got=%h exp=0", i, data_a);
                else passes++;
            end
        end
        checks++; if (served !== 8) $display("FAIL zero_served got=%0d exp=8", served); else passes++;
        checks++; if (herr_a !== 1'b0) $display("FAIL zero_herr got=%b exp=0", herr_a); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_single_word();
        test_health();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
